bcd_updown_counter_gen: RTL and testbench



---
 rtl/bcd_counter_pkg.sv | 22 ++
 rtl/bcd_digit_step.sv | 40 ++++
 rtl/bcd_updown_counter_gen.sv | 149 ++++++++++++++
 tb/tb_bcd_updown_counter_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_counter_pkg : shared types, BCD constants and sizing helper
// Rev 1.0
// ---------------------------------------------------------------------------
package bcd_counter_pkg;

  typedef enum logic [0:0] {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [3:0] NINE = 4'd9;
  localparam logic [3:0] ZERO = 4'd0;

  // A single speed still needs a one-bit index port.
  function automatic int speed_width(input int speeds);
    return (speeds > 2) ? $clog2(speeds) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_digit_step : one BCD digit of the increment/decrement ripple chain
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_digit_step
  import bcd_counter_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       down,
  input  logic       cin,
  output logic [3:0] digit_next,
  output logic       cout
);

  // cout doubles as borrow when counting down.
  always_comb begin
    digit_next = digit;
    cout       = 1'b0;
    if (cin) begin
      if (down) begin
        if (digit == ZERO) begin
          digit_next = NINE;
          cout       = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end else begin
        if (digit == NINE) begin
          digit_next = ZERO;
          cout       = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_updown_counter_gen : multi-digit up/down BCD counter with speeds,
//                          wrap/saturate mode, parallel load and wrap pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_updown_counter_gen
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SPEEDS   = 3,
  parameter int BASE_DIV = 23
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_pulse,
  input  logic                            dir,
  input  logic                            speed_up_pulse,
  input  logic                            speed_down_pulse,
  input  logic                            wrap_en,
  input  logic                            load_pulse,
  input  logic [4*DIGITS-1:0]             load_value,
  output logic [4*DIGITS-1:0]             value,
  output logic                            running,
  output logic                            dir_down,
  output logic [speed_width(SPEEDS)-1:0]  speed,
  output logic                            at_max,
  output logic                            at_min,
  output logic                            wrap_pulse
);

  localparam int SW = speed_width(SPEEDS);
  localparam int PW = BASE_DIV + SPEEDS - 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [SW-1:0] SPEED_MAX = SW'(SPEEDS - 1);

  state_e          state_q,      state_d;
  logic [VW-1:0]   value_q,      value_d;
  logic            dir_down_q,   dir_down_d;
  logic [SW-1:0]   speed_q,      speed_d;
  logic            at_max_q,     at_max_d;
  logic            at_min_q,     at_min_d;
  logic            wrap_pulse_q, wrap_pulse_d;
  logic [PW-1:0]   presc_q,      presc_d;

  logic [PW-1:0]   tick_mask;
  logic            tick;
  logic [DIGITS:0] carry;
  logic [VW-1:0]   stepped;
  logic [VW-1:0]   load_clamped;
  logic            at_bound;

  // Faster speeds watch fewer low prescaler bits, halving the tick period.
  always_comb begin
    tick_mask = '0;
    for (int i = 0; i < PW; i++) begin
      tick_mask[i] = (i < (PW - int'(speed_q)));
    end
  end
  assign tick = &(presc_q | ~tick_mask);

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (value_q[4*g +: 4]),
      .down       (dir_down_q),
      .cin        (carry[g]),
      .digit_next (stepped[4*g +: 4]),
      .cout       (carry[g+1])
    );
    assign load_clamped[4*g +: 4] =
      (load_value[4*g +: 4] > NINE) ? NINE : load_value[4*g +: 4];
  end

  // Carry out of the top digit means the count sat at all-9s (up) or zero (down).
  assign at_bound = carry[DIGITS];

  always_comb begin
    state_d = state_q;
    if (en_pulse) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end

    dir_down_d = (state_q == RUN) ? dir : dir_down_q;

    speed_d = speed_q;
    if (speed_up_pulse && !speed_down_pulse && (speed_q != SPEED_MAX)) begin
      speed_d = speed_q + SW'(1);
    end else if (speed_down_pulse && !speed_up_pulse && (speed_q != '0)) begin
      speed_d = speed_q - SW'(1);
    end

    presc_d = presc_q + PW'(1);

    value_d      = value_q;
    at_max_d     = at_max_q;
    at_min_d     = at_min_q;
    wrap_pulse_d = 1'b0;

    if (load_pulse) begin
      value_d  = load_clamped;
      at_max_d = 1'b0;
      at_min_d = 1'b0;
    end else if ((state_q == RUN) && tick) begin
      if (!at_bound || wrap_en) begin
        value_d      = stepped;
        wrap_pulse_d = at_bound;
        at_max_d     = 1'b0;
        at_min_d     = 1'b0;
      end else begin
        at_max_d = ~dir_down_q;
        at_min_d = dir_down_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PAUSE;
      value_q      <= '0;
      dir_down_q   <= 1'b0;
      speed_q      <= '0;
      at_max_q     <= 1'b0;
      at_min_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      presc_q      <= '0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      dir_down_q   <= dir_down_d;
      speed_q      <= speed_d;
      at_max_q     <= at_max_d;
      at_min_q     <= at_min_d;
      wrap_pulse_q <= wrap_pulse_d;
      presc_q      <= presc_d;
    end
  end

  assign value      = value_q;
  assign running    = (state_q == RUN);
  assign dir_down   = dir_down_q;
  assign speed      = speed_q;
  assign at_max     = at_max_q;
  assign at_min     = at_min_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter_gen : scoreboard bench with a decimal reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter_gen;

  localparam int DIGITS   = 2;
  localparam int SPEEDS   = 3;
  localparam int BASE_DIV = 2;
  localparam int SW       = (SPEEDS > 2) ? $clog2(SPEEDS) : 1;
  localparam int VW       = 4 * DIGITS;
  localparam int PW       = BASE_DIV + SPEEDS - 1;
  localparam int MAXV     = 10 ** DIGITS - 1;

  typedef struct packed {
    logic [VW-1:0] value;
    logic          running;
    logic          dir_down;
    logic [SW-1:0] speed;
    logic          at_max;
    logic          at_min;
    logic          wrap_pulse;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_pulse = 1'b0;
  logic          dir = 1'b0;
  logic          speed_up_pulse = 1'b0;
  logic          speed_down_pulse = 1'b0;
  logic          wrap_en = 1'b0;
  logic          load_pulse = 1'b0;
  logic [VW-1:0] load_value = '0;
  logic [VW-1:0] value;
  logic          running;
  logic          dir_down;
  logic [SW-1:0] speed;
  logic          at_max;
  logic          at_min;
  logic          wrap_pulse;

  always #5 clk = ~clk;

  bcd_updown_counter_gen #(
    .DIGITS   (DIGITS),
    .SPEEDS   (SPEEDS),
    .BASE_DIV (BASE_DIV)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en_pulse         (en_pulse),
    .dir              (dir),
    .speed_up_pulse   (speed_up_pulse),
    .speed_down_pulse (speed_down_pulse),
    .wrap_en          (wrap_en),
    .load_pulse       (load_pulse),
    .load_value       (load_value),
    .value            (value),
    .running          (running),
    .dir_down         (dir_down),
    .speed            (speed),
    .at_max           (at_max),
    .at_min           (at_min),
    .wrap_pulse       (wrap_pulse)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  // Reference model: count kept as a plain decimal integer.
  int m_val, m_spd, m_cnt;
  bit m_run, m_dd, m_max, m_min, m_wp;
  bit lvl_dir, lvl_wrap;

  function automatic logic [VW-1:0] to_bcd(input int v);
    logic [VW-1:0] b;
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int load_to_int(input logic [VW-1:0] b);
    int v, d;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function obs_t model_obs();
    obs_t o;
    o.value      = to_bcd(m_val);
    o.running    = m_run;
    o.dir_down   = m_dd;
    o.speed      = SW'(m_spd);
    o.at_max     = m_max;
    o.at_min     = m_min;
    o.wrap_pulse = m_wp;
    return o;
  endfunction

  function bit model_tick();
    int period;
    period = 1 << (PW - m_spd);
    return (m_cnt % period) == (period - 1);
  endfunction

  function obs_t dut_obs();
    obs_t o;
    o = {value, running, dir_down, speed, at_max, at_min, wrap_pulse};
    return o;
  endfunction

  task automatic model_reset();
    m_val = 0; m_spd = 0; m_cnt = 0;
    m_run = 0; m_dd = 0; m_max = 0; m_min = 0; m_wp = 0;
  endtask

  task automatic model_step(input bit en, input bit up, input bit dn,
                            input bit ld, input logic [VW-1:0] lv);
    int n_val, n_spd;
    bit n_run, n_dd, n_max, n_min, n_wp, t;
    t = model_tick();
    n_val = m_val; n_max = m_max; n_min = m_min; n_wp = 0;
    if (ld) begin
      n_val = load_to_int(lv); n_max = 0; n_min = 0;
    end else if (m_run && t) begin
      if (!m_dd) begin
        if (m_val < MAXV) begin n_val = m_val + 1; n_max = 0; n_min = 0; end
        else if (lvl_wrap) begin n_val = 0; n_wp = 1; n_max = 0; n_min = 0; end
        else begin n_max = 1; n_min = 0; end
      end else begin
        if (m_val > 0) begin n_val = m_val - 1; n_max = 0; n_min = 0; end
        else if (lvl_wrap) begin n_val = MAXV; n_wp = 1; n_max = 0; n_min = 0; end
        else begin n_min = 1; n_max = 0; end
      end
    end
    n_run = en ? !m_run : m_run;
    n_dd  = m_run ? lvl_dir : m_dd;
    n_spd = m_spd;
    if (up && !dn && m_spd < SPEEDS - 1) n_spd = m_spd + 1;
    if (dn && !up && m_spd > 0)          n_spd = m_spd - 1;
    m_cnt = (m_cnt + 1) % (1 << PW);
    m_val = n_val; m_run = n_run; m_dd = n_dd; m_spd = n_spd;
    m_max = n_max; m_min = n_min; m_wp = n_wp;
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got val=%h run=%b dd=%b spd=%0d max=%b min=%b wp=%b exp val=%h run=%b dd=%b spd=%0d max=%b min=%b wp=%b",
               name, $time, got.value, got.running, got.dir_down, got.speed, got.at_max,
               got.at_min, got.wrap_pulse, exp.value, exp.running, exp.dir_down, exp.speed,
               exp.at_max, exp.at_min, exp.wrap_pulse);
    end
  endtask

  task automatic drive(input bit en, input bit up, input bit dn,
                       input bit ld, input logic [VW-1:0] lv);
    @(negedge clk);
    rst              = 1'b0;
    en_pulse         = en;
    speed_up_pulse   = up;
    speed_down_pulse = dn;
    load_pulse       = ld;
    load_value       = lv;
    dir              = lvl_dir;
    wrap_en          = lvl_wrap;
    model_step(en, up, dn, ld, lv);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, '0);
  endtask

  // Reset is checked between clock edges to prove it acts asynchronously.
  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check("async_reset", dut_obs(), model_obs());
  endtask

  // Monitor: every output cycle is compared against the oldest expectation.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", dut_obs(), e);
      end
    end
  end

  initial begin
    int guard;
    lvl_dir = 0; lvl_wrap = 0;
    model_reset();
    #1;
    check("reset_state", dut_obs(), model_obs());

    // Count up at the slowest speed.
    drive(1, 0, 0, 0, '0);
    idle(40);

    // Saturate at the top, then turn around.
    drive(0, 1, 0, 1, 8'h97);
    drive(0, 1, 0, 0, '0);
    idle(20);
    lvl_dir = 1;
    idle(10);

    // Wrap from zero down to all-9s.
    lvl_wrap = 1;
    drive(0, 0, 0, 1, 8'h01);
    idle(14);

    // Speed control while paused.
    drive(1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, '0);
    drive(0, 0, 1, 0, '0);
    repeat (3) drive(0, 1, 0, 0, '0);
    drive(0, 1, 1, 0, '0);
    idle(12);

    // Clamped load, then a load that collides with a tick.
    drive(0, 0, 0, 1, 8'hAF);
    drive(1, 0, 0, 0, '0);
    lvl_dir = 0;
    idle(2);
    guard = 0;
    while (!model_tick() && guard < 64) begin
      drive(0, 0, 0, 0, '0);
      guard++;
    end
    drive(0, 0, 0, 1, 8'h35);
    idle(6);

    // Reset mid-run at 42.
    if (!m_run) drive(1, 0, 0, 0, '0);
    lvl_wrap = 0;
    drive(0, 0, 0, 1, 8'h42);
    async_reset();
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15, 0) == 0) lvl_dir  = ~lvl_dir;
      if ($urandom_range(49, 0) == 0) lvl_wrap = ~lvl_wrap;
      if ($urandom_range(599, 0) == 0) begin
        async_reset();
      end else begin
        drive($urandom_range(63, 0) == 0, $urandom_range(31, 0) == 0,
              $urandom_range(31, 0) == 0, $urandom_range(39, 0) == 0,
              VW'($urandom));
      end
    end

    idle(2);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
